// File: rtl/signed_iterative_divider.sv
// signed_iterative_divider: multi-cycle signed restoring divider (quotient, remainder, exception flag)
// Ports: clock/reset_n (async active-low); ctrl_div starts a division of data_operandA by data_operandB.
//        data_result/data_remainder/data_exception update with a one-cycle data_resultRDY pulse; busy marks work in flight.
// Option: define DIV_REMAINDER_EN to drive data_remainder; undefined ties it to 0.
module signed_iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvs, a_abs, b_abs;
    logic [WIDTH:0] trial;
    logic a_neg, b_neg, div_zero, ovf, last, q_neg, exc;
`ifdef DIV_REMAINDER_EN
    logic r_neg;
`endif
    always_comb begin
        a_neg = data_operandA[WIDTH-1];
        b_neg = data_operandB[WIDTH-1];
        a_abs = a_neg ? -data_operandA : data_operandA;
        b_abs = b_neg ? -data_operandB : data_operandB;
        div_zero = data_operandB == '0;
        ovf = data_operandA == {1'b1, {(WIDTH-1){1'b0}}} && &data_operandB;
        // WIDTH+1-bit trial subtraction of |B| from the shifted partial remainder; bit WIDTH is the borrow/sign
        trial = {rem, quo[WIDTH-1]} - {1'b0, dvs};
        last = cnt == CW'(WIDTH-1);
        state_nx = state == IDLE ? (ctrl_div ? (div_zero ? DONE : RUN) : IDLE)
                 : state == RUN  ? (last ? DONE : RUN)
                 : IDLE;
    end
    assign busy = state != IDLE;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            rem            <= '0;
            quo            <= '0;
            dvs            <= '0;
            q_neg          <= 1'b0;
            exc            <= 1'b0;
`ifdef DIV_REMAINDER_EN
            r_neg          <= 1'b0;
`endif
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state)
                IDLE: if (ctrl_div) begin
                    cnt   <= '0;
                    dvs   <= b_abs;
                    // divide-by-zero preloads the raw dividend as remainder and a zero quotient, unsigned
                    quo   <= div_zero ? '0 : a_abs;
                    rem   <= div_zero ? data_operandA : '0;
                    q_neg <= !div_zero && (a_neg ^ b_neg);
                    exc   <= div_zero || ovf;
`ifdef DIV_REMAINDER_EN
                    r_neg <= !div_zero && a_neg;
`endif
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    quo <= {quo[WIDTH-2:0], !trial[WIDTH]};
                    rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
                end
                DONE: begin
                    data_result    <= q_neg ? -quo : quo;
`ifdef DIV_REMAINDER_EN
                    data_remainder <= r_neg ? -rem : rem;
`else
                    data_remainder <= '0;
`endif
                    data_exception <= exc;
                    data_resultRDY <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_iterative_divider.sv
// tb_signed_iterative_divider: random and directed checks of the divider against an arithmetic model
module tb_signed_iterative_divider;
    logic clock = 1'b0, reset_n = 1'b0, ctrl_div = 1'b0;
    logic [31:0] opa = '0, opb = '0, res, rmd;
    logic exc, rdy, busy;
    int checks = 0, errors = 0;
    signed_iterative_divider #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
        .data_operandA(opa), .data_operandB(opb),
        .data_result(res), .data_remainder(rmd),
        .data_exception(exc), .data_resultRDY(rdy), .busy(busy)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e, output int lat);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 0) begin
            q = '0; r = a; e = 1'b1; lat = 1;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb);
            e = (a == 32'h8000_0000) && (b == 32'hffff_ffff); lat = 33;
        end
`ifndef DIV_REMAINDER_EN
        r = '0;
`endif
    endtask
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        opa = a; opb = b; ctrl_div = 1'b1;
        @(posedge clock); #1;
        ctrl_div = 1'b0; opa = $urandom; opb = $urandom;
        check("busy_start", busy, 1);
    endtask
    task automatic wait_rdy(input int inject, output int lat);
        lat = 0;
        while (!rdy && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            ctrl_div = lat == inject;
            if (lat == inject) begin opa = 9; opb = 3; end
        end
        ctrl_div = 1'b0;
    endtask
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inject);
        logic [31:0] q, r;
        logic e;
        int want, lat;
        model(a, b, q, r, e, want);
        start(a, b);
        wait_rdy(inject, lat);
        check("latency", lat, want);
        check("quotient", res, q);
        check("remainder", rmd, r);
        check("exception", exc, e);
        check("busy_done", busy, 0);
        @(posedge clock); #1;
        check("rdy_pulse", rdy, 0);
        check("hold_q", res, q);
    endtask
    initial begin
        int lat, pulses;
        logic [31:0] a, b;
        #2;
        check("rst_q", res, 0);
        check("rst_r", rmd, 0);
        check("rst_e", exc, 0);
        check("rst_rdy", rdy, 0);
        check("rst_busy", busy, 0);
        @(posedge clock); #2;
        reset_n = 1'b1;
        run_div(32'd100, 32'd7, 0);
        run_div(32'hffff_ff9c, 32'd7, 0);
        run_div(32'd5, 32'd0, 0);
        run_div(32'h8000_0000, 32'hffff_ffff, 0);
        run_div(32'h8000_0000, 32'h0000_0001, 0);
        run_div(32'h7fff_ffff, 32'h8000_0000, 0);
        run_div(32'h8000_0000, 32'h8000_0000, 0);
        run_div(32'hffff_fff9, 32'hffff_fffe, 0);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? $urandom_range(0, 20) - 10 : $urandom;
            if (i % 4 == 1) a = $urandom_range(0, 2000) - 1000;
            run_div(a, b, 0);
        end
        // a start request mid-run must be dropped, not queued
        run_div(32'd100, 32'd7, 10);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (rdy) pulses++;
        end
        check("no_queued_start", pulses, 0);
        // back-to-back: start in the cycle right after the result pulse
        start(32'd100, 32'd7);
        wait_rdy(0, lat);
        @(negedge clock);
        opa = 32'd9; opb = 32'd3; ctrl_div = 1'b1;
        @(posedge clock); #1;
        ctrl_div = 1'b0;
        check("b2b_busy", busy, 1);
        wait_rdy(0, lat);
        check("b2b_latency", lat, 33);
        check("b2b_q", res, 3);
        // asynchronous reset mid-run aborts with no result pulse
        start(32'd100, 32'd7);
        repeat (16) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("arst_q", res, 0);
        check("arst_e", exc, 0);
        check("arst_rdy", rdy, 0);
        check("arst_busy", busy, 0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (rdy) pulses++;
        end
        check("abort_no_rdy", pulses, 0);
        run_div(32'd9, 32'd3, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
